// File: rtl/tff_mod_counter.sv
// rtl/tff_mod_counter.sv - modulo-N up/down counter built from per-bit T cells
// Load/clamp, terminal-count, sticky wrap flag and optional saturating mode.

module tff_cell (
  input  logic clk,
  input  logic clr,
  input  logic t,
  output logic q
);
  always_ff @(posedge clk or posedge clr) begin
    if (clr)    q <= 1'b0;
    else if (t) q <= ~q;
  end
endmodule

module tff_mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int ONESHOT = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);
  // MODULUS may equal 2^WIDTH, so the range compare needs one extra bit.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX   = WIDTH'(MODULUS - 1);

  logic             at_max;
  logic             at_zero;
  logic             wrap;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] toggle;

  assign at_max       = (q == MAX);
  assign at_zero      = (q == '0);
  assign tc           = en & ((up & at_max) | (~up & at_zero));
  assign wrap         = tc & ~load;
  assign load_clamped = ({1'b0, load_val} < MOD_W) ? load_val : MAX;

  always_comb begin
    next_q = q;
    if (load) begin
      next_q = load_clamped;
    end else if (en) begin
      if (up) begin
        if (!at_max)           next_q = q + WIDTH'(1);
        else if (ONESHOT == 0) next_q = '0;
      end else begin
        if (!at_zero)          next_q = q - WIDTH'(1);
        else if (ONESHOT == 0) next_q = MAX;
      end
    end
  end

  // Each storage bit only toggles; the toggle is the next-state difference.
  assign toggle = next_q ^ q;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    tff_cell u_cell (
      .clk (clk),
      .clr (clr),
      .t   (toggle[b]),
      .q   (q[b])
    );
  end

  // Set beats clear when both land on the same edge.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)          ovf <= 1'b0;
    else if (wrap)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end
endmodule

// File: tb/tb_tff_mod_counter.sv
// tb/tb_tff_mod_counter.sv - directed-vector bench for tff_mod_counter
// Wrap instance (MODULUS=10) and one-shot instance share all stimulus.

module tb_tff_mod_counter;
  logic       clk = 1'b0;
  logic       clr, en, up, load, ovf_clr;
  logic [3:0] load_val;
  logic [3:0] q0, q1;
  logic       tc0, tc1, ovf0, ovf1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tff_mod_counter #(.WIDTH(4), .MODULUS(10), .ONESHOT(0)) dut_wrap (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .q(q0), .tc(tc0), .ovf(ovf0)
  );

  tff_mod_counter #(.WIDTH(4), .MODULUS(10), .ONESHOT(1)) dut_sat (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
    .ovf_clr(ovf_clr), .q(q1), .tc(tc1), .ovf(ovf1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; ovf_clr = 1'b0; load_val = 4'd0;
    step(); step();
    check("rst_q", q0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_tc_en0", tc0, 0);
    en = 1'b1; up = 1'b0; #1;
    check("rst_tc_down", tc0, 1);
    up = 1'b1; #1;
    check("rst_tc_up", tc0, 0);
    clr = 1'b0;

    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("up_q%0d", i), q0, i % 10);
      check($sformatf("up_tc%0d", i), tc0, (i % 10) == 9);
      check($sformatf("up_ovf%0d", i), ovf0, i >= 10);
    end

    en = 1'b0; ovf_clr = 1'b1;
    step();
    check("ovfclr", ovf0, 0);
    check("ovfclr_hold", q0, 2);
    ovf_clr = 1'b0;

    load = 1'b1; load_val = 4'd2;
    step();
    check("ld2", q0, 2);
    load = 1'b0; en = 1'b1; up = 1'b0;
    step(); check("dn_q1", q0, 1); check("dn_ovf1", ovf0, 0);
    step(); check("dn_q0", q0, 0); check("dn_tc0", tc0, 1); check("dn_ovf0", ovf0, 0);
    step(); check("dn_q9", q0, 9); check("dn_ovf9", ovf0, 1);
    up = 1'b1;
    step(); check("dir_q", q0, 0); check("dir_ovf", ovf0, 1);

    load = 1'b1; load_val = 4'd7;
    step(); check("ld7", q0, 7); check("ld7_ovf", ovf0, 1);
    load_val = 4'd13;
    step(); check("ld13_clamp", q0, 9); check("ld13_ovf", ovf0, 1);
    load = 1'b0; en = 1'b0; ovf_clr = 1'b1;
    step(); check("clr2_ovf", ovf0, 0); check("clr2_q", q0, 9);
    ovf_clr = 1'b0; load = 1'b1; load_val = 4'd15; en = 1'b1; up = 1'b1;
    step(); check("ld15_clamp", q0, 9); check("ld_no_wrap_ovf", ovf0, 0);

    load = 1'b0; ovf_clr = 1'b1; #1;
    check("coll_tc", tc0, 1);
    step(); check("coll_q", q0, 0); check("coll_ovf", ovf0, 1);
    en = 1'b0;
    step(); check("coll2_ovf", ovf0, 0); check("coll2_q", q0, 0);
    ovf_clr = 1'b0;

    load = 1'b1; load_val = 4'd9;
    step();
    load = 1'b0; en = 1'b1;
    step(); check("pre_rst_ovf", ovf0, 1);
    load = 1'b1; load_val = 4'd4;
    step();
    load = 1'b0;
    step(); check("pre_rst_q", q0, 5);
    #2 clr = 1'b1; #1;
    check("arst_q", q0, 0);
    check("arst_ovf", ovf0, 0);
    load = 1'b1; load_val = 4'd7;
    step(); step();
    check("arst_hold_q", q0, 0);
    clr = 1'b0; load = 1'b0;
    step(); check("post_rst_q", q0, 1);

    clr = 1'b1; en = 1'b0; #2; clr = 1'b0;
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("os_q%0d", i), q1, (i < 9) ? i : 9);
      check($sformatf("os_tc%0d", i), tc1, i >= 9);
      check($sformatf("os_ovf%0d", i), ovf1, i >= 10);
    end
    en = 1'b0; ovf_clr = 1'b1; load = 1'b1; load_val = 4'd0;
    step(); check("os_ovfclr", ovf1, 0); check("os_ld0", q1, 0);
    ovf_clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b0;
    step();
    check("os_dn_hold", q1, 0); check("os_dn_ovf", ovf1, 1);
    check("wr_dn_wrap", q0, 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/tff_mod_counter.md
# tff_mod_counter

Parametrised synchronous modulo-N up/down counter built from T-flip-flop cells, one per bit. It is the multi-bit, configurable successor to the single-bit T-from-JK storage element, adding:

- programmable modulus;
- count direction;
- parallel load;
- terminal-count and sticky-wrap flags;
- optional one-shot (saturating) mode.

It serves as the general event/divide counter for sequential blocks in this library.

## Interface
Parameters:
- WIDTH, 4, counter width in bits (1..16)
- MODULUS, 16, count range 0..MODULUS-1; legal 2..2^WIDTH
- ONESHOT, 0, 0 = wrap at terminal; 1 = hold at terminal (saturate)

Ports:
- clk  input  1  clock, all state updates on rising edge
- clr  input  1  reset, asynchronous, active-high; clears all state immediately
- en  input  1  count enable, sampled at clk rise
- up  input  1  direction: 1 = increment, 0 = decrement
- load  input  1  synchronous parallel load, priority over en
- load_val  input  WIDTH  value for load
- ovf_clr  input  1  synchronous clear of ovf
- q  output  WIDTH  registered count
- tc  output  1  combinational terminal count
- ovf  output  1  registered sticky wrap/saturation-attempt flag

## Operation
- Storage: each bit of q is a T cell. Its toggle input is computed from the next-state function; bit b toggles iff next_q[b] != q[b]. No per-bit asynchronous logic other than clr.
- Priority at each clk rise, highest first: clr (async), load, en, hold.
- clr=1: q=0, ovf=0 immediately and while asserted. Edges during clr are ignored.
- Load:
  - load=1: q <= load_val if load_val < MODULUS, else q <= MODULUS-1 (clamped).
  - ovf unaffected by load. en is ignored that cycle.
- Count (en=1, load=0):
  - up=1, q < MODULUS-1: q <= q+1.
  - up=1, q = MODULUS-1: ONESHOT=0 gives q <= 0 and ovf set; ONESHOT=1 gives q holds and ovf set.
  - up=0, q > 0: q <= q-1.
  - up=0, q = 0: ONESHOT=0 gives q <= MODULUS-1 and ovf set; ONESHOT=1 gives q holds and ovf set.
- Hold (en=0, load=0): q unchanged.
- tc = en & ((up & q==MODULUS-1) | (~up & q==0)). It flags that the next enabled edge wraps or saturates, and can cascade into a following counter's en.
- ovf:
  - Set on any wrap/saturation event as defined above.
  - Cleared by ovf_clr=1 at clk rise.
  - If set and clear occur on the same edge, set wins and ovf=1.
- Direction may change on any cycle; it takes effect at the next edge with no extra latency.
- Arithmetic is modulo MODULUS, not 2^WIDTH. q never holds a value >= MODULUS after any edge.
- MODULUS = 2^WIDTH reduces to a plain binary counter, where every bit's toggle equals AND of lower bits (up) or AND of inverted lower bits (down).

## Timing
- Reset values: q=0, ovf=0, tc=en&~up (combinational).
- Latency:
  - load, count and ovf update: 1 clk edge.
  - tc: 0 cycles (combinational from q, en, up).
- clr assertion is asynchronous. Deassertion must meet recovery to clk; the first counting edge is the first rise after deassertion.
- Reset mid-count: q and ovf return to 0 within the same cycle, regardless of load or en.
- No multicycle paths; the next-state adder/comparator must close in one clk period at WIDTH=16.

## Test plan
- Setup: WIDTH=4, MODULUS=10, ONESHOT=0 unless stated.
- Reset/up wrap: clr 1 for 2 cycles, then en=1, up=1 for 12 edges -> q sequence 1..9,0,1,2. tc=1 only while q=9. ovf rises on the 9->0 edge and stays 1.
- Down wrap and direction change: load 2, then en=1, up=0 for 3 edges -> q=1,0,9 with ovf set on 0->9. Set up=1 for 1 edge -> q=0.
- Load priority and clamp: en=1, load=1, load_val=7 -> q=7 (not 8). Then load_val=13 -> q=9. ovf unchanged by both.
- ovf set/clear collision: q=9, en=1, up=1, ovf_clr=1 same edge -> q=0, ovf=1. Next edge with ovf_clr=1, en=0 -> ovf=0, q holds 0.
- One-shot (ONESHOT=1): from q=0, en=1, up=1 for 12 edges -> q reaches 9 and holds for 3 edges. ovf set on the first edge at 9. tc stays 1 while q=9.
- Async reset mid-operation: counting at q=5, assert clr between edges -> q=0, ovf=0 before the next edge. Edges during clr leave q=0. After deassertion the first edge with en=1, up=1 -> q=1.
